// File: rtl/kl_ram_target_pkg.sv
// Shared types, KLink size constants and the beat-count helper for kl_ram_target.
// The WACK state exists only when KL_RAM_WRITE_ACK_EN is defined.
package kl_ram_target_pkg;

   localparam logic [2:0] KL_SIZE_B = 3'd0;
   localparam logic [2:0] KL_SIZE_H = 3'd1;
   localparam logic [2:0] KL_SIZE_W = 3'd2;
   localparam logic [2:0] KL_SIZE_D = 3'd3;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_WBURST = 2'd1,
`ifdef KL_RAM_WRITE_ACK_EN
      ST_RBURST = 2'd2,
      ST_WACK   = 2'd3
`else
      ST_RBURST = 2'd2
`endif
   } kl_state_e;

   // Anything up to a doubleword is one beat; larger sizes are 8-byte beats.
   function automatic logic [4:0] kl_beats(input logic [2:0] size);
      if (size <= KL_SIZE_D) return 5'd1;
      else return 5'd1 << (size - KL_SIZE_D);
   endfunction

endpackage

// File: rtl/kl_ram_sram.sv
// Synchronous single-port 64-bit SRAM with byte write enables.
// One-cycle read latency; the output register holds while the read enable is low.
module kl_ram_sram
   import kl_ram_target_pkg::*;
#(
   parameter int ADDR_BITS = 10
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 en_i,
   input  logic                 we_i,
   input  logic [7:0]           wmask_i,
   input  logic [ADDR_BITS-1:0] addr_i,
   input  logic [63:0]          wdata_i,
   output logic [63:0]          rdata_o
);

   logic [63:0] mem_q [2**ADDR_BITS];
   logic [63:0] rdata_q;

   always_ff @(posedge clk_i) begin
      if (en_i && we_i) begin
         for (int b = 0; b < 8; b++) begin
            if (wmask_i[b]) mem_q[addr_i][b*8 +: 8] <= wdata_i[b*8 +: 8];
         end
      end
   end

   // Only the output register is reset; array contents survive reset.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) rdata_q <= '0;
      else if (en_i && !we_i) rdata_q <= mem_q[addr_i];
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/kl_ram_target.sv
// KLink memory target: one request at a time, burst reads/writes into kl_ram_sram.
// Define KL_RAM_WRITE_ACK_EN to answer each completed write with a one-beat ack.
module kl_ram_target
   import kl_ram_target_pkg::*;
#(
   parameter int ADDR_BITS       = 10,
   parameter int MAX_BURST_WIDTH = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] req_addr,
   input  logic        req_wen,
   input  logic [63:0] req_wdata,
   input  logic [7:0]  req_wmask,
   input  logic [2:0]  req_size,
   input  logic [4:0]  req_srcid,
   input  logic        req_valid,
   output logic        req_ready,
   output logic [63:0] resp_rdata,
   output logic [2:0]  resp_size,
   output logic [4:0]  resp_dstid,
   output logic        resp_valid,
   input  logic        resp_ready,
   output kl_state_e   dbg_state_o
);

   kl_state_e                  state_q;
   logic                       resp_valid_q;
   logic [MAX_BURST_WIDTH-1:0] cnt_q;
   logic [MAX_BURST_WIDTH-1:0] idx_q;
   logic [ADDR_BITS-1:0]       base_q;
   logic [4:0]                 srcid_q;
   logic [2:0]                 size_q;

   logic [4:0]                 beats_d;
   logic [4:0]                 beats_m1_d;
   logic [MAX_BURST_WIDTH-1:0] cnt_init_d;
   logic [ADDR_BITS-1:0]       word_d;
   logic [ADDR_BITS-1:0]       base_d;
   logic [ADDR_BITS-1:0]       beat_addr_d;

   logic                       sram_en;
   logic                       sram_we;
   logic [7:0]                 sram_wmask;
   logic [ADDR_BITS-1:0]       sram_addr;
   logic [63:0]                sram_rdata;
   logic                       unused_addr;

   assign beats_d     = kl_beats(req_size);
   assign beats_m1_d  = beats_d - 5'd1;
   assign cnt_init_d  = beats_m1_d[MAX_BURST_WIDTH-1:0];
   assign word_d      = req_addr[ADDR_BITS+2:3];
   assign base_d      = word_d & ~ADDR_BITS'(beats_m1_d);
   assign beat_addr_d = base_q + ADDR_BITS'(idx_q);
   // Bits above the SRAM depth alias; byte offset is covered by wmask.
   assign unused_addr = ^{req_addr[31:ADDR_BITS+3], req_addr[2:0]};

   always_comb begin
      req_ready = 1'b0;
      if (!rst) begin
         case (state_q)
            ST_IDLE:   req_ready = !resp_valid_q;
            ST_WBURST: req_ready = 1'b1;
            default:   req_ready = 1'b0;
         endcase
      end
   end

   always_comb begin
      sram_en    = 1'b0;
      sram_we    = 1'b0;
      sram_addr  = beat_addr_d;
      sram_wmask = 8'h00;
      case (state_q)
         ST_IDLE: begin
            if (req_valid && req_ready) begin
               sram_en    = 1'b1;
               sram_we    = req_wen;
               sram_addr  = base_d;
               sram_wmask = req_wmask;
            end
         end
         ST_WBURST: begin
            if (req_valid) begin
               sram_en    = 1'b1;
               sram_we    = 1'b1;
               sram_wmask = req_wmask;
            end
         end
         // Prefetch the next beat only when the presented one leaves this cycle.
         ST_RBURST: sram_en = (!resp_valid_q || resp_ready) && (cnt_q != '0);
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         resp_valid_q <= 1'b0;
         cnt_q        <= '0;
         idx_q        <= '0;
         base_q       <= '0;
         srcid_q      <= '0;
         size_q       <= '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (req_valid && req_ready) begin
                  srcid_q <= req_srcid;
                  size_q  <= req_size;
                  base_q  <= base_d;
                  cnt_q   <= cnt_init_d;
                  idx_q   <= MAX_BURST_WIDTH'(1);
                  if (!req_wen) begin
                     state_q      <= ST_RBURST;
                     resp_valid_q <= 1'b1;
                  end else if (cnt_init_d != '0) begin
                     state_q <= ST_WBURST;
                  end
`ifdef KL_RAM_WRITE_ACK_EN
                  else begin
                     state_q      <= ST_WACK;
                     size_q       <= KL_SIZE_D;
                     resp_valid_q <= 1'b1;
                  end
`endif
               end
            end
            ST_WBURST: begin
               if (req_valid) begin
                  idx_q <= idx_q + MAX_BURST_WIDTH'(1);
                  cnt_q <= cnt_q - MAX_BURST_WIDTH'(1);
                  if (cnt_q == MAX_BURST_WIDTH'(1)) begin
`ifdef KL_RAM_WRITE_ACK_EN
                     state_q      <= ST_WACK;
                     size_q       <= KL_SIZE_D;
                     resp_valid_q <= 1'b1;
`else
                     state_q <= ST_IDLE;
`endif
                  end
               end
            end
            ST_RBURST: begin
               if (resp_valid_q && resp_ready) begin
                  if (cnt_q == '0) begin
                     state_q      <= ST_IDLE;
                     resp_valid_q <= 1'b0;
                  end else begin
                     idx_q <= idx_q + MAX_BURST_WIDTH'(1);
                     cnt_q <= cnt_q - MAX_BURST_WIDTH'(1);
                  end
               end
            end
`ifdef KL_RAM_WRITE_ACK_EN
            ST_WACK: begin
               if (resp_ready) begin
                  state_q      <= ST_IDLE;
                  resp_valid_q <= 1'b0;
               end
            end
`endif
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   kl_ram_sram #(
      .ADDR_BITS (ADDR_BITS)
   ) u_sram (
      .clk_i   (clk),
      .rst_i   (rst),
      .en_i    (sram_en),
      .we_i    (sram_we),
      .wmask_i (sram_wmask),
      .addr_i  (sram_addr),
      .wdata_i (req_wdata),
      .rdata_o (sram_rdata)
   );

   assign resp_valid  = resp_valid_q;
   assign resp_rdata  = (state_q == ST_RBURST) ? sram_rdata : 64'd0;
   assign resp_size   = size_q;
   assign resp_dstid  = srcid_q;
   assign dbg_state_o = state_q;

endmodule

// File: tb/tb_kl_ram_target.sv
// Directed bench for kl_ram_target: writes, masked writes, bursts, back-pressure,
// aliasing, reset mid-burst and (with KL_RAM_WRITE_ACK_EN) the write ack.
module tb_kl_ram_target;
   import kl_ram_target_pkg::*;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] req_addr = '0;
   logic        req_wen = 1'b0;
   logic [63:0] req_wdata = '0;
   logic [7:0]  req_wmask = '0;
   logic [2:0]  req_size = '0;
   logic [4:0]  req_srcid = '0;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic [63:0] resp_rdata;
   logic [2:0]  resp_size;
   logic [4:0]  resp_dstid;
   logic        resp_valid;
   logic        resp_ready = 1'b1;
   kl_state_e   dbg_state;

   int          n_checks = 0;
   int          n_errors = 0;
   logic [63:0] exp_q[$];

   kl_ram_target dut (
      .clk         (clk),
      .rst         (rst),
      .req_addr    (req_addr),
      .req_wen     (req_wen),
      .req_wdata   (req_wdata),
      .req_wmask   (req_wmask),
      .req_size    (req_size),
      .req_srcid   (req_srcid),
      .req_valid   (req_valid),
      .req_ready   (req_ready),
      .resp_rdata  (resp_rdata),
      .resp_size   (resp_size),
      .resp_dstid  (resp_dstid),
      .resp_valid  (resp_valid),
      .resp_ready  (resp_ready),
      .dbg_state_o (dbg_state)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s got=%h want=%h", tag, obs, exp);
      end
   endtask

   function automatic int beats_of(input logic [2:0] size);
      return (size <= 3'd3) ? 1 : (1 << (int'(size) - 3));
   endfunction

   task automatic wait_ready(input string tag);
      int wc = 0;
      while (!req_ready && wc < 50) begin
         @(negedge clk);
         wc++;
      end
      if (!req_ready) check(tag, 64'd0, 64'd1);
   endtask

   // Beat i carries d0+i; later beats drive junk control fields that must be ignored.
   task automatic write_burst(input logic [31:0] addr, input logic [2:0] size,
                              input logic [4:0] src, input logic [63:0] d0,
                              input logic [7:0] mask);
      int n = beats_of(size);
      @(negedge clk);
      req_valid = 1'b1;
      req_wen   = 1'b1;
      req_addr  = addr;
      req_size  = size;
      req_srcid = src;
      for (int i = 0; i < n; i++) begin
         req_wdata = d0 + 64'(i);
         req_wmask = mask;
         if (i > 0) begin
            req_addr  = 32'h0000_03F8;
            req_srcid = 5'h1F;
            req_wen   = 1'b0;
            req_size  = 3'd0;
         end
         wait_ready("wr_ready_timeout");
         @(negedge clk);
      end
      req_valid = 1'b0;
      req_wen   = 1'b0;
`ifdef KL_RAM_WRITE_ACK_EN
      check("wack_valid", 64'(resp_valid), 64'd1);
      check("wack_dstid", 64'(resp_dstid), 64'(src));
      check("wack_rdata", resp_rdata, 64'd0);
      check("wack_size", 64'(resp_size), 64'd3);
      check("wack_req_ready", 64'(req_ready), 64'd0);
      resp_ready = 1'b1;
      @(negedge clk);
      check("wack_done", 64'(resp_valid), 64'd0);
`else
      check("wr_no_resp", 64'(resp_valid), 64'd0);
`endif
      check("wr_ready_after", 64'(req_ready), 64'd1);
   endtask

   // Expects beats d0..d0+n-1; resp_ready follows pat[cycle % 4].
   task automatic read_burst(input logic [31:0] addr, input logic [2:0] size,
                             input logic [4:0] src, input logic [63:0] d0,
                             input logic [3:0] pat);
      int   n = beats_of(size);
      int   got = 0;
      int   cyc = 0;
      logic rdy_seen = 1'b0;
      exp_q.delete();
      for (int i = 0; i < n; i++) exp_q.push_back(d0 + 64'(i));
      @(negedge clk);
      req_valid = 1'b1;
      req_wen   = 1'b0;
      req_addr  = addr;
      req_size  = size;
      req_srcid = src;
      wait_ready("rd_ready_timeout");
      @(negedge clk);
      req_valid = 1'b0;
      check("rd_latency", 64'(resp_valid), 64'd1);
      while (got < n && cyc < 200) begin
         resp_ready = pat[cyc % 4];
         if (!resp_valid) begin
            check("rd_valid_gap", 64'd0, 64'd1);
            break;
         end
         check("rd_data", resp_rdata, exp_q[0]);
         if (resp_ready) begin
            check("rd_dstid", 64'(resp_dstid), 64'(src));
            check("rd_size", 64'(resp_size), 64'(size));
            void'(exp_q.pop_front());
            got++;
         end
         if (req_ready) rdy_seen = 1'b1;
         cyc++;
         @(negedge clk);
      end
      check("rd_beats", 64'(got), 64'(n));
      if (pat == 4'hF) check("rd_cycles", 64'(cyc), 64'(n));
      check("rd_req_ready_low", 64'(rdy_seen), 64'd0);
      check("rd_end_valid", 64'(resp_valid), 64'd0);
      check("rd_end_ready", 64'(req_ready), 64'd1);
      resp_ready = 1'b1;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog got=timeout want=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      #2;
      check("rst_req_ready", 64'(req_ready), 64'd0);
      check("rst_resp_valid", 64'(resp_valid), 64'd0);
      check("rst_rdata", resp_rdata, 64'd0);
      check("rst_dstid", 64'(resp_dstid), 64'd0);
      repeat (3) @(negedge clk);
      rst = 1'b0;
      #1;
      check("post_rst_ready", 64'(req_ready), 64'd1);

      write_burst(32'h10, 3'd3, 5'd1, 64'h1122334455667788, 8'hFF);
      read_burst(32'h10, 3'd3, 5'd1, 64'h1122334455667788, 4'hF);

      write_burst(32'h18, 3'd3, 5'd2, 64'd0, 8'hFF);
      write_burst(32'h18, 3'd0, 5'd2, 64'hFFFF_FFFF_FFFF_FFFF, 8'h01);
      read_burst(32'h1C, 3'd2, 5'd3, 64'h0000_0000_0000_00FF, 4'hF);

      write_burst(32'h40, 3'd5, 5'd4, 64'hA0, 8'hFF);
      read_burst(32'h48, 3'd5, 5'd6, 64'hA0, 4'hF);

      write_burst(32'h80, 3'd6, 5'd7, 64'hB0, 8'hFF);
      read_burst(32'h98, 3'd6, 5'd8, 64'hB0, 4'b1001);

      write_burst(32'h100, 3'd7, 5'd9, 64'hC00, 8'hFF);
      read_burst(32'h178, 3'd7, 5'd10, 64'hC00, 4'hF);

      write_burst(32'h2010, 3'd3, 5'd11, 64'hDEAD_BEEF_0000_0001, 8'hFF);
      read_burst(32'h10, 3'd3, 5'd12, 64'hDEAD_BEEF_0000_0001, 4'hF);

`ifdef KL_RAM_WRITE_ACK_EN
      write_burst(32'h200, 3'd4, 5'd5, 64'hE0, 8'hFF);
      read_burst(32'h200, 3'd4, 5'd5, 64'hE0, 4'hF);
`endif

      // Reset while beat 2 of a read burst is on the response channel.
      resp_ready = 1'b1;
      @(negedge clk);
      req_valid = 1'b1;
      req_wen   = 1'b0;
      req_addr  = 32'h40;
      req_size  = 3'd5;
      req_srcid = 5'd13;
      wait_ready("mid_ready_timeout");
      @(negedge clk);
      req_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      check("mid_beat2", resp_rdata, 64'hA2);
      #2;
      rst = 1'b1;
      #1;
      check("mid_rst_valid", 64'(resp_valid), 64'd0);
      check("mid_rst_ready", 64'(req_ready), 64'd0);
      check("mid_rst_rdata", resp_rdata, 64'd0);
      check("mid_rst_dstid", 64'(resp_dstid), 64'd0);
      check("mid_rst_state", 64'(dbg_state), 64'(ST_IDLE));
      @(negedge clk);
      rst = 1'b0;
      read_burst(32'h40, 3'd5, 5'd14, 64'hA0, 4'hF);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
